// File: rtl/quad_paddle_decoder.sv
// ---------------------------------------------------------------------------
// quad_paddle_decoder
//
// Turns the raw paddle encoder quadrature pins into a clean, clamped paddle
// position for the pong core. Each raw pin is synchronised, then debounced.
// The debounced pair is decoded as a 4-state Gray sequence, and the decoded
// steps move a saturating position counter.
//
// Handshake: there is no backpressure. step_valid and error are one-cycle
// strobes that are never high together. position and dir are level outputs.
// dir holds its value between steps. Consumers sample position whenever
// they like, and sample dir on a step_valid strobe.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   quadA      raw encoder channel A (asynchronous)
//   quadB      raw encoder channel B (asynchronous)
//   position   registered paddle position, clamped to [POS_MIN, POS_MAX]
//   step_valid one-cycle strobe: a legal step was decoded (even if clamped)
//   dir        direction of the last legal step (1 = up, 0 = down)
//   error      one-cycle strobe: both filtered bits changed at once
// ---------------------------------------------------------------------------
module quad_paddle_decoder #(
    parameter int POS_W    = 9,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = 511 - 120,
    parameter int POS_INIT = 128,
    parameter int DEB_CNT  = 1000,
    parameter int DEB_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             quadA,
    input  logic             quadB,
    output logic [POS_W-1:0] position,
    output logic             step_valid,
    output logic             dir,
    output logic             error
);

    localparam logic [POS_W-1:0] P_MIN    = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] P_MAX    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_INIT   = POS_W'(POS_INIT);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

    typedef enum logic {
        ST_PRIME = 1'b0,  // waiting for both channels to settle after reset
        ST_RUN   = 1'b1   // decoding transitions
    } state_t;

    state_t state, state_next;

    // Channel bit 1 is A, bit 0 is B, so every 2-bit vector reads {A,B}.
    logic [1:0]       raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [DEB_W-1:0] cnt [2];
    logic [DEB_W-1:0] prime_cnt;
    logic [1:0]       prev;
    logic [1:0]       cur;
    logic             stable;

    logic             prime_load;
    logic             is_change;
    logic             is_err;
    logic             is_up;
    logic [POS_W-1:0] pos_next;

    assign raw    = {quadA, quadB};
    assign cur    = deb;
    assign stable = (sync2 == deb);

    // Two-flop synchroniser per channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: a change is accepted only after the synchronised input has
    // disagreed with the filtered value for DEB_CNT consecutive cycles. Any
    // agreement restarts the count, so shorter glitches never get through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= 2'b00;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Priming stability counter: number of consecutive cycles that both
    // channels have had no pending change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_cnt <= '0;
        end else if (state == ST_PRIME) begin
            if (!stable)
                prime_cnt <= '0;
            else if (prime_cnt != DEB_LAST)
                prime_cnt <= prime_cnt + DEB_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_PRIME;
        else      state <= state_next;
    end

    // Next state and decode.
    always_comb begin
        state_next = state;
        prime_load = 1'b0;
        is_change  = 1'b0;
        is_err     = 1'b0;
        is_up      = 1'b0;
        pos_next   = position;
        case (state)
            ST_PRIME: begin
                // The encoder may rest in any state at reset release. Its
                // current filtered value is adopted as the reference, so no
                // motion is produced.
                if (stable && prime_cnt == DEB_LAST) begin
                    state_next = ST_RUN;
                    prime_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (cur != prev) begin
                    is_change = 1'b1;
                    if ((cur ^ prev) == 2'b11) begin
                        is_err = 1'b1;
                    end else begin
                        // Along 00->10->11->01->00, new B always equals old A.
                        // Along the reverse order, it always differs.
                        is_up = (cur[0] == prev[1]);
                        if (is_up)
                            pos_next = (position == P_MAX) ? position
                                                           : position + POS_W'(1);
                        else
                            pos_next = (position == P_MIN) ? position
                                                           : position - POS_W'(1);
                    end
                end
            end
        endcase
    end

    // Registered outputs and reference state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev       <= 2'b00;
            position   <= P_INIT;
            step_valid <= 1'b0;
            dir        <= 1'b0;
            error      <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            error      <= 1'b0;
            if (prime_load) begin
                prev <= cur;
            end else if (is_change) begin
                prev <= cur;
                if (is_err) begin
                    error <= 1'b1;
                end else begin
                    step_valid <= 1'b1;
                    dir        <= is_up;
                    position   <= pos_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_paddle_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_paddle_decoder
//
// Directed bench with DEB_CNT = 4. Stimulus tasks push the expected strobe
// into exp_q at the moment an input change is driven:
//   {is_error, dir, position}
// They also push the cycle at which the strobe is due into exp_t_q. A
// separate monitor compares every step_valid/error strobe against the head
// of the queue. Any strobe with nothing expected counts as a failure.
// ---------------------------------------------------------------------------
module tb_quad_paddle_decoder;

    localparam int POS_W = 9;
    localparam int P_MAX = 391;
    localparam int DEB   = 4;
    // Input driven at a negedge; first sampled at the next posedge k.
    // Outputs move at edge k+2+DEB, seen at the negedge after it.
    localparam int LAT   = DEB + 3;

    logic             clk;
    logic             rst;
    logic             quadA;
    logic             quadB;
    logic [POS_W-1:0] position;
    logic             step_valid;
    logic             dir;
    logic             error;

    quad_paddle_decoder #(
        .POS_W(POS_W), .POS_MIN(0), .POS_MAX(P_MAX), .POS_INIT(128),
        .DEB_CNT(DEB), .DEB_W(3)
    ) dut (
        .clk(clk), .rst(rst), .quadA(quadA), .quadB(quadB),
        .position(position), .step_valid(step_valid), .dir(dir), .error(error)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [POS_W+1:0] exp_q[$];
    int               exp_t_q[$];
    int               tests = 0;
    int               fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit err, input bit d, input int pos);
        exp_q.push_back({err, d, POS_W'(pos)});
        exp_t_q.push_back(cyc + LAT);
    endtask

    logic [POS_W+1:0] mon_e;
    int               mon_t;

    always @(negedge clk) begin
        if (rst === 1'b1 && (step_valid === 1'b1 || error === 1'b1)) begin
            check("strobe_exclusive", {31'd0, step_valid & error}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: step_valid=%0d error=%0d position=%0d, expected no strobe (cycle %0d)",
                         step_valid, error, position, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                check("strobe_is_error", {31'd0, error}, {31'd0, mon_e[POS_W+1]});
                check("strobe_dir", {31'd0, dir}, {31'd0, mon_e[POS_W]});
                check("strobe_position", {23'd0, position}, {23'd0, mon_e[POS_W-1:0]});
                check("strobe_cycle", cyc, mon_t);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [1:0] cur_ab;
    int         exp_pos;
    bit         exp_dir;

    function automatic logic [1:0] next_ab(input logic [1:0] ab, input bit up);
        logic [1:0] n;
        case (ab)
            2'b00:   n = up ? 2'b10 : 2'b01;
            2'b10:   n = up ? 2'b11 : 2'b00;
            2'b11:   n = up ? 2'b01 : 2'b10;
            default: n = up ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

    task automatic set_ab(input logic [1:0] ab);
        @(negedge clk);
        quadA  = ab[1];
        quadB  = ab[0];
        cur_ab = ab;
    endtask

    task automatic step(input bit up, input int hold);
        set_ab(next_ab(cur_ab, up));
        if (up) exp_pos = (exp_pos == P_MAX) ? P_MAX : exp_pos + 1;
        else    exp_pos = (exp_pos == 0) ? 0 : exp_pos - 1;
        exp_dir = up;
        push(1'b0, up, exp_pos);
        repeat (hold) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] fwd_ab  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    int         fwd_pos [4] = '{129, 130, 131, 132};

    initial begin
        rst     = 1'b0;
        quadA   = 1'b0;
        quadB   = 1'b0;
        cur_ab  = 2'b00;
        exp_pos = 128;
        exp_dir = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_position", {23'd0, position}, 32'd128);
        check("reset_step_valid", {31'd0, step_valid}, 32'd0);
        check("reset_dir", {31'd0, dir}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);

        // Release at 00; priming must be silent.
        @(negedge clk) rst = 1'b1;
        repeat (20) @(negedge clk);
        check("primed_position", {23'd0, position}, 32'd128);
        check("primed_error", {31'd0, error}, 32'd0);

        // Forward cycle, each state held 10 cycles.
        for (int i = 0; i < 4; i++) begin
            set_ab(fwd_ab[i]);
            push(1'b0, 1'b1, fwd_pos[i]);
            repeat (10) @(negedge clk);
        end
        exp_pos = 132;
        exp_dir = 1'b1;
        check("fwd_position", {23'd0, position}, 32'd132);
        check("fwd_dir", {31'd0, dir}, 32'd1);

        // Simultaneous change 00 -> 11: error only.
        set_ab(2'b11);
        push(1'b1, 1'b1, 132);
        repeat (10) @(negedge clk);
        check("err_position", {23'd0, position}, 32'd132);
        check("err_dir", {31'd0, dir}, 32'd1);
        step(1'b1, 10);   // 11 -> 01, up to 133
        step(1'b0, 10);   // 01 -> 11, down to 132
        check("after_err_position", {23'd0, position}, 32'd132);
        check("after_err_dir", {31'd0, dir}, 32'd0);

        // 3-cycle glitch on quadA with quadB static at 1.
        @(negedge clk) quadA = 1'b0;
        repeat (3) @(negedge clk);
        quadA = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_position", {23'd0, position}, 32'd132);

        // Walk down to 1, then five more steps: reaches 0 and holds.
        for (int i = 0; i < 131; i++) step(1'b0, 8);
        check("walk_down_position", {23'd0, position}, 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 8);
        check("min_clamp_position", {23'd0, position}, 32'd0);
        check("min_clamp_dir", {31'd0, dir}, 32'd0);

        // Walk up past the top: holds at 391.
        for (int i = 0; i < P_MAX + 3; i++) step(1'b1, 8);
        check("max_clamp_position", {23'd0, position}, P_MAX);
        check("max_clamp_dir", {31'd0, dir}, 32'd1);

        // Reset with inputs at 11, then release.
        @(negedge clk);
        rst    = 1'b0;
        quadA  = 1'b1;
        quadB  = 1'b1;
        cur_ab = 2'b11;
        #1;
        check("rst11_position", {23'd0, position}, 32'd128);
        check("rst11_dir", {31'd0, dir}, 32'd0);
        exp_pos = 128;
        exp_dir = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("rel11_position", {23'd0, position}, 32'd128);
        check("rel11_error", {31'd0, error}, 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 8);
        check("before_midrst_position", {23'd0, position}, 32'd140);

        // Reset pulsed low while a change is in flight.
        set_ab(next_ab(cur_ab, 1'b1));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_position", {23'd0, position}, 32'd128);
        check("midrst_step_valid", {31'd0, step_valid}, 32'd0);
        exp_pos = 128;
        exp_dir = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("rel_mid_position", {23'd0, position}, 32'd128);
        check("rel_mid_error", {31'd0, error}, 32'd0);
        step(1'b1, 10);
        check("reprimed_position", {23'd0, position}, 32'd129);

        // Drain: anything still expected never arrived.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_t = exp_t_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_strobe: no strobe observed, expected position=%0d dir=%0d error=%0d at cycle %0d",
                     mon_e[POS_W-1:0], mon_e[POS_W], mon_e[POS_W+1], mon_t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
